// File: rtl/fx3_stream_out_reader.sv
// fx3_stream_out_reader: FX3 slave-FIFO read master for the host->FPGA stream.
// Reads BURST_LEN-word bursts from the consumer socket into an internal FWFT FIFO
// and presents them as a valid/ready stream.
// Optional build macro FX3_RD_CHECK_EN adds a counting-pattern checker on the
// captured words. The outputs chk_err and chk_err_cnt exist only in that build.
module fx3_stream_out_reader #(
  parameter int          DATA_W    = 16,
  parameter int          BURST_LEN = 512,
  parameter int          RD_LAT    = 2,
  parameter int          FLAG_WAIT = 3,
  parameter int          FIFO_AW   = 10,
  parameter logic [1:0]  SOCK_ADDR = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_c,
  input  logic [DATA_W-1:0] usb_data,
  output logic              slcs,
  output logic              sloe,
  output logic              slrd,
  output logic              slwr,
  output logic              pktend,
  output logic [1:0]        fifo_addr,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              ovf
`ifdef FX3_RD_CHECK_EN
  ,
  output logic              chk_err,
  output logic [15:0]       chk_err_cnt
`endif
);

  localparam int                 DEPTH   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0]        BL_M1   = 16'(BURST_LEN - 1);
  localparam logic [15:0]        LAT_M1  = 16'(RD_LAT - 1);
  localparam logic [15:0]        WT_M1   = 16'(FLAG_WAIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_OE, S_READ, S_DRAIN, S_WAIT} state_t;

  state_t             state, state_nxt;
  logic [15:0]        cnt, cnt_nxt;
  logic [RD_LAT-1:0]  rd_pipe;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, free;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               push, push_ok, pop_ok, full, room;

  // Write strobe and packet end are never used on this path.
  assign slwr      = 1'b1;
  assign pktend    = 1'b1;
  assign fifo_addr = SOCK_ADDR;

  assign busy  = (state != S_IDLE);
  assign full  = (count == DEPTH_C);
  assign free  = DEPTH_C - count;
  // Reserve a whole burst plus in-flight words so a stalled consumer can never overflow.
  assign room  = 32'(free) >= 32'(BURST_LEN + RD_LAT);

  // Next-state logic: fixed-length READ/DRAIN/WAIT phases, no early exit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      S_IDLE:  if (flag_c && room) begin state_nxt = S_OE; cnt_nxt = '0; end
      S_OE:    begin state_nxt = S_READ; cnt_nxt = '0; end
      S_READ:  if (cnt == BL_M1) begin state_nxt = S_DRAIN; cnt_nxt = '0; end
               else cnt_nxt = cnt + 16'd1;
      S_DRAIN: if (cnt == LAT_M1) begin state_nxt = S_WAIT; cnt_nxt = '0; end
               else cnt_nxt = cnt + 16'd1;
      S_WAIT:  if (cnt == WT_M1) begin state_nxt = S_IDLE; cnt_nxt = '0; end
               else cnt_nxt = cnt + 16'd1;
      default: begin state_nxt = S_IDLE; cnt_nxt = '0; end
    endcase
  end

  // State register; strobes are registered from the next state so pins track state with no input-to-pin path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      slcs  <= 1'b1;
      sloe  <= 1'b1;
      slrd  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      slcs  <= (state_nxt == S_IDLE) || (state_nxt == S_WAIT);
      sloe  <= (state_nxt == S_IDLE) || (state_nxt == S_WAIT);
      slrd  <= (state_nxt != S_READ);
    end
  end

  // Read-latency delay line: a word is on usb_data when the asserted strobe reaches the tail.
  always_ff @(posedge clk) begin
    if (rst) rd_pipe <= '0;
    else begin
      rd_pipe[0] <= ~slrd;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign push    = rd_pipe[RD_LAT-1];
  assign push_ok = push && !full;
  assign pop_ok  = m_ready && (count != '0);

  // FIFO storage; head is read asynchronously for first-word fall-through.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= usb_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) ovf <= 1'b1;
    end
  end

  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];

`ifdef FX3_RD_CHECK_EN
  logic [DATA_W-1:0] chk_exp;

  // Pattern checker: expects an incrementing count and resyncs to the received word after a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_exp     <= '0;
      chk_err     <= 1'b0;
      chk_err_cnt <= '0;
    end else begin
      chk_err <= 1'b0;
      if (push) begin
        if (usb_data != chk_exp) begin
          chk_err <= 1'b1;
          if (chk_err_cnt != 16'hFFFF) chk_err_cnt <= chk_err_cnt + 16'd1;
          chk_exp <= usb_data + 1'b1;
        end else begin
          chk_exp <= chk_exp + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fx3_stream_out_reader.sv
// Bench for fx3_stream_out_reader: FX3 read model feeds a scoreboard queue,
// a monitor pops and compares on every stream handshake and checks burst shape.
module tb_fx3_stream_out_reader;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0, rst = 1'b1, flag_c = 1'b0, m_ready = 1'b0;
  logic [15:0] usb_data = '0;
  logic        slcs, sloe, slrd, slwr, pktend, m_valid, busy, ovf;
  logic [1:0]  fifo_addr;
  logic [15:0] m_data;
`ifdef FX3_RD_CHECK_EN
  logic        chk_err;
  logic [15:0] chk_err_cnt;
`endif

  fx3_stream_out_reader dut (
    .clk(clk), .rst(rst), .flag_c(flag_c), .usb_data(usb_data),
    .slcs(slcs), .sloe(sloe), .slrd(slrd), .slwr(slwr), .pktend(pktend),
    .fifo_addr(fifo_addr), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .ovf(ovf)
`ifdef FX3_RD_CHECK_EN
    , .chk_err(chk_err), .chk_err_cnt(chk_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s got %0h expected %0h", nm, got, exp);
  endtask

  // FX3 model: counting data appears RD_LAT cycles after each strobed cycle.
  logic [15:0]     sb[$];
  logic [RD_LAT:0] mp = '0;
  logic [15:0]     midx = '0;
  int              mcnt = 0;
  bit              inject = 0;
  always @(negedge clk) begin
    if (rst) begin
      mp = '0; midx = '0; usb_data = '0;
    end else begin
      mp = {mp[RD_LAT-1:0], ~slrd};
      if (mp[RD_LAT]) begin
        if (inject && midx == 16'd37) begin usb_data = 16'hBEEF; midx = 16'hBEF0; end
        else begin usb_data = midx; midx = midx + 16'd1; end
        sb.push_back(usb_data);
        mcnt++;
      end
    end
  end

  // Consumer ready: 0 = stalled, 1 = always, 2 = random.
  int rmode = 0;
  always @(posedge clk) begin
    #1;
    if (rmode == 2) m_ready = 1'($urandom_range(0, 1));
    else            m_ready = (rmode == 1);
  end

  // Monitor: scoreboard pops, burst length and OE pin checks.
  int run = 0, srun = 0, bursts = 0, pops = 0, errs = 0;
  logic [15:0] exp_w;
  always @(negedge clk) begin
    if (rst) begin
      run = 0; srun = 0;
    end else begin
      if (busy) begin
        run++;
        if (run == 1) begin bursts++; chk("oe_pins", int'({slcs, sloe, slrd}), 1); end
      end else if (run != 0) begin
        chk("busy_len", run, 518); run = 0;
      end
      if (!slrd) srun++;
      else if (srun != 0) begin chk("rd_len", srun, 512); srun = 0; end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) chk("sb_empty_pop", 1, 0);
        else begin exp_w = sb.pop_front(); chk("data", int'(m_data), int'(exp_w)); end
        pops++;
      end
`ifdef FX3_RD_CHECK_EN
      if (chk_err) errs++;
`endif
    end
  end

  task automatic wait_bursts(input int target, input int lim);
    for (int i = 0; i < lim && bursts < target; i++) @(negedge clk);
    chk("burst_start", int'(bursts >= target), 1);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && (busy || m_valid || sb.size() != 0); i++) @(negedge clk);
    chk("drained", int'(!busy && !m_valid && sb.size() == 0), 1);
  endtask

  int b0, m0, p0;
  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_slcs", int'(slcs), 1);
    chk("rst_sloe", int'(sloe), 1);
    chk("rst_slrd", int'(slrd), 1);
    chk("rst_slwr", int'(slwr), 1);
    chk("rst_pktend", int'(pktend), 1);
    chk("rst_addr", int'(fifo_addr), 3);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
`ifdef FX3_RD_CHECK_EN
    chk("rst_chk_cnt", int'(chk_err_cnt), 0);
    inject = 1;
`endif
    rst = 1'b0;

    // Single burst, consumer always ready
    rmode = 1; flag_c = 1'b1;
    wait_bursts(1, 20);
    flag_c = 1'b0;
    drain(3000);
`ifdef FX3_RD_CHECK_EN
    chk("chk_err_cnt", int'(chk_err_cnt), 1);
    chk("chk_err_pulses", errs, 1);
    inject = 0;
`endif

    // Stalled consumer: reservation allows only one burst
    b0 = bursts; m0 = mcnt; rmode = 0; flag_c = 1'b1;
    repeat (1500) @(negedge clk);
    chk("stall_bursts", bursts - b0, 1);
    chk("stall_words", mcnt - m0, 512);
    chk("stall_valid", int'(m_valid), 1);
    chk("stall_busy", int'(busy), 0);
    chk("stall_ovf", int'(ovf), 0);
    flag_c = 1'b0; rmode = 1;
    drain(3000);

    // Four bursts with random back-pressure
    b0 = bursts; m0 = mcnt; p0 = pops; rmode = 2; flag_c = 1'b1;
    wait_bursts(b0 + 4, 20000);
    flag_c = 1'b0;
    drain(10000);
    chk("rand_pops", pops - p0, 2048);
    chk("rand_words", mcnt - m0, 2048);

    // Reset in the middle of a burst
    rmode = 0; m0 = mcnt; flag_c = 1'b1;
    for (int i = 0; i < 400 && (mcnt - m0) < 100; i++) @(negedge clk);
    chk("mid_reached", int'((mcnt - m0) >= 100), 1);
    rst = 1'b1; flag_c = 1'b0;
    @(negedge clk);
    chk("mid_rst_pins", int'({slcs, sloe, slrd}), 7);
    chk("mid_rst_valid", int'(m_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk);
    sb.delete();
    rst = 1'b0;
    b0 = bursts; p0 = pops; rmode = 1; flag_c = 1'b1;
    wait_bursts(b0 + 1, 20);
    flag_c = 1'b0;
    drain(3000);
    chk("restart_pops", pops - p0, 512);

    // Three bursts with concurrent pop: pointers wrap
    b0 = bursts; p0 = pops; flag_c = 1'b1;
    wait_bursts(b0 + 3, 5000);
    flag_c = 1'b0;
    drain(3000);
    chk("wrap_pops", pops - p0, 1536);
    chk("final_ovf", int'(ovf), 0);
`ifdef FX3_RD_CHECK_EN
    chk("final_chk_cnt", int'(chk_err_cnt), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
